// File: rtl/knight_move_sequencer_pkg.sv
// Shared definitions for the knight move sequencer.
//   - piece type codes, colours, file/rank names
//   - bit positions of the piece word {type,col,row,color} and of the formatted move
//   - knight offset table (k0..k7, clockwise from top-left)
//   - FSM state encoding
package knight_move_sequencer_pkg;

    // Piece type codes
    localparam logic [2:0] PT_EMPTY  = 3'd0;
    localparam logic [2:0] PT_PAWN   = 3'd1;
    localparam logic [2:0] PT_KNIGHT = 3'd2;
    localparam logic [2:0] PT_BISHOP = 3'd3;
    localparam logic [2:0] PT_ROOK   = 3'd4;
    localparam logic [2:0] PT_QUEEN  = 3'd5;
    localparam logic [2:0] PT_KING   = 3'd6;

    // Colours
    localparam logic COLOR_WHITE = 1'b0;
    localparam logic COLOR_BLACK = 1'b1;

    // File (column) and rank (row) names
    localparam logic [2:0] FILE_A = 3'd0;
    localparam logic [2:0] FILE_H = 3'd7;
    localparam logic [2:0] RANK_1 = 3'd0;
    localparam logic [2:0] RANK_8 = 3'd7;

    // Piece word field positions
    localparam int PC_TYPE_MSB = 9;
    localparam int PC_TYPE_LSB = 7;
    localparam int PC_COL_MSB  = 6;
    localparam int PC_COL_LSB  = 4;
    localparam int PC_ROW_MSB  = 3;
    localparam int PC_ROW_LSB  = 1;
    localparam int PC_COLOR    = 0;

    // Formatted move field positions {2'b0,promo,capture,sc,sr,dc,dr}
    localparam int MV_PROMO_BIT   = 13;
    localparam int MV_CAPTURE_BIT = 12;

    // Square address of the last board square
    localparam logic [5:0] SQ_LAST = {FILE_H, RANK_8};

    typedef struct packed {
        logic signed [3:0] dc;
        logic signed [3:0] dr;
    } knight_off_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_SRC,
        ST_WT_SRC,
        ST_NEXT_OFF,
        ST_RD_DST,
        ST_WT_DST,
        ST_CHECK,
        ST_EMIT,
        ST_ADV_SQ,
        ST_DONE
    } seq_state_t;

    // Knight offsets, top-left then clockwise.
    function automatic knight_off_t knight_offset(input logic [2:0] k);
        knight_off_t off;
        case (k)
            3'd0:    off = '{dc: -4'sd1, dr:  4'sd2};
            3'd1:    off = '{dc:  4'sd1, dr:  4'sd2};
            3'd2:    off = '{dc:  4'sd2, dr:  4'sd1};
            3'd3:    off = '{dc:  4'sd2, dr: -4'sd1};
            3'd4:    off = '{dc:  4'sd1, dr: -4'sd2};
            3'd5:    off = '{dc: -4'sd1, dr: -4'sd2};
            3'd6:    off = '{dc: -4'sd2, dr: -4'sd1};
            default: off = '{dc: -4'sd2, dr:  4'sd1};
        endcase
        return off;
    endfunction

endpackage

// File: rtl/knight_move_sequencer_target_calc.sv
// knight_target_calc: combinational knight target square.
// Ports:
//   i_src_col, i_src_row  source square
//   i_k                   offset index 0..7
//   o_tgt_col, o_tgt_row  target square (meaningful only when o_on_board)
//   o_on_board            target lies inside the 8x8 board
module knight_target_calc
    import knight_move_sequencer_pkg::*;
(
    input  logic [2:0] i_src_col,
    input  logic [2:0] i_src_row,
    input  logic [2:0] i_k,
    output logic [2:0] o_tgt_col,
    output logic [2:0] o_tgt_row,
    output logic       o_on_board
);

    knight_off_t       w_off;
    logic signed [3:0] w_col_s;
    logic signed [3:0] w_row_s;

    assign w_off   = knight_offset(i_k);
    assign w_col_s = $signed({1'b0, i_src_col}) + w_off.dc;
    assign w_row_s = $signed({1'b0, i_src_row}) + w_off.dr;

    // Results span -2..9; in 4-bit signed 8 and 9 wrap negative, so the
    // sign bit alone flags every off-board coordinate.
    assign o_on_board = !w_col_s[3] && !w_row_s[3];
    assign o_tgt_col  = w_col_s[2:0];
    assign o_tgt_row  = w_row_s[2:0];

endmodule

// File: rtl/knight_move_sequencer.sv
// knight_move_sequencer: scans the board RAM for knights of the side to move,
// presents each on-board (src, dest) pair to an external move checker and
// forwards accepted moves as a valid/ready stream.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_start, i_abort, i_side   scan control; side sampled on start
//   o_board_addr, o_board_rd   board RAM read port {col,row}
//   i_board_rdata              piece word, valid RD_LAT cycles after o_board_rd
//   o_src_piece, o_dest_piece  pair under evaluation, to the checker
//   i_chk_valid, i_chk_move    checker verdict and formatted move
//   o_move_out, o_move_valid,
//   i_move_ready               accepted-move stream
//   o_busy, o_done             scan in progress / 1-cycle completion pulse
//   o_move_count               moves emitted this scan, saturating
// Build option: KNIGHT_SEQ_CAPTURES_ONLY_EN -- when defined only capturing
// moves are emitted.
module knight_move_sequencer
    import knight_move_sequencer_pkg::*;
#(
    parameter int RD_LAT  = 1,
    parameter int COUNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_side,
    output logic [5:0]         o_board_addr,
    output logic               o_board_rd,
    input  logic [9:0]         i_board_rdata,
    output logic [9:0]         o_src_piece,
    output logic [9:0]         o_dest_piece,
    input  logic               i_chk_valid,
    input  logic [15:0]        i_chk_move,
    output logic [15:0]        o_move_out,
    output logic               o_move_valid,
    input  logic               i_move_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic [COUNT_W-1:0] o_move_count
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    seq_state_t         r_state;
    logic [5:0]         r_sq;
    logic [3:0]         r_k;
    logic [1:0]         r_wait;
    logic               r_side;
    logic [5:0]         r_addr;
    logic               r_rd;
    logic [9:0]         r_src;
    logic [9:0]         r_dest;
    logic [15:0]        r_move;
    logic               r_mvalid;
    logic               r_busy;
    logic               r_done;
    logic [COUNT_W-1:0] r_count;

    logic [2:0]         w_tgt_col;
    logic [2:0]         w_tgt_row;
    logic               w_on_board;
    logic               w_src_mine;
    logic               w_accept;

    knight_target_calc u_target_calc (
        .i_src_col  (r_sq[5:3]),
        .i_src_row  (r_sq[2:0]),
        .i_k        (r_k[2:0]),
        .o_tgt_col  (w_tgt_col),
        .o_tgt_row  (w_tgt_row),
        .o_on_board (w_on_board)
    );

    assign w_src_mine = (i_board_rdata[PC_TYPE_MSB:PC_TYPE_LSB] == PT_KNIGHT) &&
                        (i_board_rdata[PC_COLOR] == r_side);

`ifdef KNIGHT_SEQ_CAPTURES_ONLY_EN
    assign w_accept = i_chk_valid && i_chk_move[MV_CAPTURE_BIT];
`else
    assign w_accept = i_chk_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sq     <= '0;
            r_k      <= '0;
            r_wait   <= '0;
            r_side   <= COLOR_WHITE;
            r_addr   <= '0;
            r_rd     <= 1'b0;
            r_src    <= '0;
            r_dest   <= '0;
            r_move   <= '0;
            r_mvalid <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
        end else begin
            // Read strobe and done are single-cycle unless re-armed below.
            r_rd   <= 1'b0;
            r_done <= 1'b0;
            if (i_abort && (r_state != ST_IDLE)) begin
                // Abort wins over any pending handshake: the move is dropped.
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_mvalid <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start && !i_abort) begin
                            r_side  <= i_side;
                            r_sq    <= '0;
                            r_addr  <= '0;
                            r_rd    <= 1'b1;
                            r_busy  <= 1'b1;
                            r_count <= '0;
                            r_state <= ST_RD_SRC;
                        end
                    end
                    ST_RD_SRC: begin
                        r_wait  <= '0;
                        r_state <= ST_WT_SRC;
                    end
                    ST_WT_SRC: begin
                        if (r_wait == LAT_LAST) begin
                            r_src <= i_board_rdata;
                            r_k   <= '0;
                            r_state <= w_src_mine ? ST_NEXT_OFF : ST_ADV_SQ;
                        end else begin
                            r_wait <= r_wait + 2'd1;
                        end
                    end
                    ST_NEXT_OFF: begin
                        if (r_k[3]) begin
                            r_state <= ST_ADV_SQ;
                        end else if (w_on_board) begin
                            r_addr  <= {w_tgt_col, w_tgt_row};
                            r_rd    <= 1'b1;
                            r_state <= ST_RD_DST;
                        end else begin
                            // Off-board targets never touch the RAM.
                            r_k <= r_k + 4'd1;
                        end
                    end
                    ST_RD_DST: begin
                        r_wait  <= '0;
                        r_state <= ST_WT_DST;
                    end
                    ST_WT_DST: begin
                        if (r_wait == LAT_LAST) begin
                            r_dest  <= i_board_rdata;
                            r_state <= ST_CHECK;
                        end else begin
                            r_wait <= r_wait + 2'd1;
                        end
                    end
                    ST_CHECK: begin
                        // src/dest have been stable for this whole cycle.
                        if (w_accept) begin
                            r_move   <= i_chk_move;
                            r_mvalid <= 1'b1;
                            r_state  <= ST_EMIT;
                        end else begin
                            r_k     <= r_k + 4'd1;
                            r_state <= ST_NEXT_OFF;
                        end
                    end
                    ST_EMIT: begin
                        if (i_move_ready) begin
                            r_mvalid <= 1'b0;
                            if (r_count != '1) begin
                                r_count <= r_count + 1'b1;
                            end
                            r_k     <= r_k + 4'd1;
                            r_state <= ST_NEXT_OFF;
                        end
                    end
                    ST_ADV_SQ: begin
                        if (r_sq == SQ_LAST) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_sq    <= r_sq + 6'd1;
                            r_addr  <= r_sq + 6'd1;
                            r_rd    <= 1'b1;
                            r_state <= ST_RD_SRC;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_board_addr = r_addr;
    assign o_board_rd   = r_rd;
    assign o_src_piece  = r_src;
    assign o_dest_piece = r_dest;
    assign o_move_out   = r_move;
    assign o_move_valid = r_mvalid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_move_count = r_count;

endmodule

// File: tb/tb_knight_move_sequencer.sv
// Testbench for knight_move_sequencer: board RAM model, move checker model,
// and a square-by-square reference scan computed from the chess rules.
`timescale 1ns/1ps
module tb_knight_move_sequencer;

    localparam int RD_LAT  = 1;
    localparam int COUNT_W = 6;
    localparam int MAX_CNT = (1 << COUNT_W) - 1;

`ifdef KNIGHT_SEQ_CAPTURES_ONLY_EN
    localparam bit CAP_ONLY = 1'b1;
`else
    localparam bit CAP_ONLY = 1'b0;
`endif

    localparam logic [2:0] T_EMPTY  = 3'd0;
    localparam logic [2:0] T_PAWN   = 3'd1;
    localparam logic [2:0] T_KNIGHT = 3'd2;
    localparam logic WHITE = 1'b0;
    localparam logic BLACK = 1'b1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               side = 1'b0;
    logic [5:0]         board_addr;
    logic               board_rd;
    logic [9:0]         board_rdata;
    logic [9:0]         src_piece;
    logic [9:0]         dest_piece;
    logic               chk_valid;
    logic [15:0]        chk_move;
    logic [15:0]        move_out;
    logic               move_valid;
    logic               move_ready = 1'b0;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] move_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    knight_move_sequencer #(.RD_LAT(RD_LAT), .COUNT_W(COUNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .i_side       (side),
        .o_board_addr (board_addr),
        .o_board_rd   (board_rd),
        .i_board_rdata(board_rdata),
        .o_src_piece  (src_piece),
        .o_dest_piece (dest_piece),
        .i_chk_valid  (chk_valid),
        .i_chk_move   (chk_move),
        .o_move_out   (move_out),
        .o_move_valid (move_valid),
        .i_move_ready (move_ready),
        .o_busy       (busy),
        .o_done       (done),
        .o_move_count (move_count)
    );

    // Board RAM with registered read
    logic [9:0] mem [64];
    logic [9:0] rd_s0 = '0;
    logic [9:0] rd_s1 = '0;
    always @(posedge clk) begin
        if (board_rd) rd_s0 <= mem[board_addr];
        rd_s1 <= rd_s0;
    end
    assign board_rdata = (RD_LAT == 1) ? rd_s0 : rd_s1;

    // Move checker: a knight may land on an empty or enemy-occupied square
    always_comb begin
        chk_valid = (src_piece[9:7] == T_KNIGHT) &&
                    ((dest_piece[9:7] == T_EMPTY) || (dest_piece[0] != src_piece[0]));
        chk_move  = {2'b00, 1'b0, (dest_piece[9:7] != T_EMPTY),
                     src_piece[6:4], src_piece[3:1], dest_piece[6:4], dest_piece[3:1]};
    end

    // Stream monitor
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    int done_cnt = 0;
    int rd_cnt   = 0;
    bit rand_ready = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (move_valid && move_ready && !abort) begin
                $display("  move %0d: %h", got_q.size(), move_out);
                got_q.push_back(move_out);
            end
            if (done) done_cnt++;
            if (board_rd) rd_cnt++;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        if (rand_ready) move_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic logic [9:0] mk(input logic [2:0] t, input int c, input int r, input logic col);
        return {t, 3'(c), 3'(r), col};
    endfunction

    task automatic clear_board();
        for (int sq = 0; sq < 64; sq++) mem[sq] = mk(T_EMPTY, sq / 8, sq % 8, WHITE);
    endtask

    task automatic place(input logic [2:0] t, input int c, input int r, input logic col);
        mem[c * 8 + r] = mk(t, c, r, col);
    endtask

    // Reference: every legal knight target, squares in address order, offsets clockwise
    task automatic model_scan(input logic s);
        int dc[8] = '{-1, 1, 2, 2, 1, -1, -2, -2};
        int dr[8] = '{ 2, 2, 1, -1, -2, -2, -1, 1};
        exp_q.delete();
        for (int sq = 0; sq < 64; sq++) begin
            int c = sq / 8;
            int r = sq % 8;
            if (mem[sq][9:7] == T_KNIGHT && mem[sq][0] == s) begin
                for (int k = 0; k < 8; k++) begin
                    int tc = c + dc[k];
                    int tr = r + dr[k];
                    if (tc >= 0 && tc < 8 && tr >= 0 && tr < 8) begin
                        logic [9:0] d = mem[tc * 8 + tr];
                        bit cap = (d[9:7] != T_EMPTY);
                        if ((!cap || d[0] != s) && (!CAP_ONLY || cap))
                            exp_q.push_back({3'b000, cap, 3'(c), 3'(r), 3'(tc), 3'(tr)});
                    end
                end
            end
        end
    endtask

    task automatic start_scan(input logic s);
        got_q.delete();
        done_cnt = 0;
        rd_cnt   = 0;
        @(posedge clk); #1;
        side  = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (done) begin
                to = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(output bit to);
        to = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (move_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({board_addr, board_rd, src_piece, dest_piece, move_out, move_valid, busy, done, move_count} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got addr=%h rd=%b src=%h dst=%h mv=%h v=%b busy=%b done=%b cnt=%0d, all required 0",
                     board_addr, board_rd, src_piece, dest_piece, move_out, move_valid, busy, done, move_count);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_lone_center();
        bit to;
        clear_board();
        place(T_KNIGHT, 3, 3, WHITE);
        model_scan(WHITE);
        move_ready = 1'b1;
        start_scan(WHITE);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL center_busy: got %b required 1", busy); end
        wait_done(to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL center_timeout: no done within budget"); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL center_nmoves: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL center_move%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
`ifndef KNIGHT_SEQ_CAPTURES_ONLY_EN
        n_checks++;
        if (got_q.size() == 0 || got_q[0] !== 16'h06D5) begin n_errors++; $display("FAIL center_first: got %0d moves, first required 06d5", got_q.size()); end
`endif
        n_checks++;
        if (move_count !== COUNT_W'(exp_q.size())) begin n_errors++; $display("FAIL center_count: got %0d required %0d", move_count, exp_q.size()); end
        n_checks++;
        if (done_cnt != 1) begin n_errors++; $display("FAIL center_done: got %0d done cycles required 1", done_cnt); end
        n_checks++;
        if (rd_cnt != 72) begin n_errors++; $display("FAIL center_reads: got %0d required 72", rd_cnt); end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL center_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_corner();
        bit to;
        clear_board();
        place(T_KNIGHT, 0, 0, WHITE);
        model_scan(WHITE);
        move_ready = 1'b1;
        start_scan(WHITE);
        wait_done(to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL corner_timeout: no done within budget"); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL corner_nmoves: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL corner_move%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
`ifndef KNIGHT_SEQ_CAPTURES_ONLY_EN
        n_checks++;
        if (got_q.size() != 2 || got_q[0] !== 16'h000A || got_q[1] !== 16'h0011) begin
            n_errors++; $display("FAIL corner_pair: got %0d moves, required 000a then 0011", got_q.size());
        end
        n_checks++;
        if (rd_cnt != 66) begin n_errors++; $display("FAIL corner_reads: got %0d required 66", rd_cnt); end
`endif
    endtask

    task automatic test_wrong_side();
        bit to;
        clear_board();
        place(T_KNIGHT, 5, 2, BLACK);
        move_ready = 1'b1;
        start_scan(WHITE);
        wait_done(to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL side_timeout: no done within budget"); end
        n_checks++;
        if (got_q.size() != 0) begin n_errors++; $display("FAIL side_nmoves: got %0d required 0", got_q.size()); end
        n_checks++;
        if (move_count !== '0) begin n_errors++; $display("FAIL side_count: got %0d required 0", move_count); end
        n_checks++;
        if (rd_cnt != 64 || done_cnt != 1) begin n_errors++; $display("FAIL side_scan: got %0d reads %0d done, required 64 and 1", rd_cnt, done_cnt); end
    endtask

    task automatic test_stall();
        bit to;
        logic [15:0] held;
        clear_board();
        place(T_KNIGHT, 3, 3, WHITE);
        place(T_PAWN, 2, 5, WHITE);
        model_scan(WHITE);
        move_ready = 1'b0;
        start_scan(WHITE);
        wait_valid(to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL stall_timeout: no move_valid within budget"); end
        held = move_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (move_valid !== 1'b1 || move_out !== held) begin
                n_errors++; $display("FAIL stall_hold%0d: got v=%b %h required v=1 %h", i, move_valid, move_out, held);
            end
        end
        @(posedge clk); #1;
        move_ready = 1'b1;
        wait_done(to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL stall_done_timeout: no done within budget"); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL stall_nmoves: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL stall_move%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
`ifndef KNIGHT_SEQ_CAPTURES_ONLY_EN
        n_checks++;
        if (got_q.size() != 7 || held !== 16'h06E5) begin n_errors++; $display("FAIL stall_seven: got %0d moves first %h, required 7 first 06e5", got_q.size(), held); end
`endif
    endtask

    task automatic test_abort();
        bit to;
        clear_board();
        place(T_KNIGHT, 3, 3, WHITE);
        move_ready = 1'b0;
        start_scan(WHITE);
        wait_valid(to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL abort_timeout: no move_valid within budget"); end
        @(posedge clk); #1;
        abort = 1'b1;
        move_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        move_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || move_valid !== 1'b0 || move_count !== '0) begin
            n_errors++; $display("FAIL abort_state: got busy=%b v=%b cnt=%0d required 0 0 0", busy, move_valid, move_count);
        end
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || got_q.size() != 0 || done_cnt != 0) begin
            n_errors++; $display("FAIL abort_quiet: got busy=%b moves=%0d done=%0d required 0 0 0", busy, got_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid_emit();
        bit to;
        clear_board();
        place(T_KNIGHT, 3, 3, WHITE);
        model_scan(WHITE);
        move_ready = 1'b0;
        start_scan(WHITE);
        wait_valid(to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL rstemit_timeout: no move_valid within budget"); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({board_addr, board_rd, src_piece, dest_piece, move_out, move_valid, busy, done, move_count} !== '0) begin
            n_errors++; $display("FAIL rstemit_outputs: got rd=%b v=%b mv=%h busy=%b cnt=%0d, all required 0",
                                 board_rd, move_valid, move_out, busy, move_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (got_q.size() != 0) begin n_errors++; $display("FAIL rstemit_partial: got %0d moves required 0", got_q.size()); end
        move_ready = 1'b1;
        start_scan(WHITE);
        wait_done(to);
        n_checks++;
        if (got_q.size() != exp_q.size() || move_count !== COUNT_W'(exp_q.size())) begin
            n_errors++; $display("FAIL rstemit_rescan: got %0d moves cnt=%0d required %0d", got_q.size(), move_count, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rstemit_move%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_captures_only();
        bit to;
        clear_board();
        place(T_KNIGHT, 3, 3, WHITE);
        place(T_PAWN, 4, 5, BLACK);
        model_scan(WHITE);
        move_ready = 1'b1;
        start_scan(WHITE);
        wait_done(to);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL capt_nmoves: got %0d required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL capt_move%0d: got %h required %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++;
`ifdef KNIGHT_SEQ_CAPTURES_ONLY_EN
        if (got_q.size() != 1 || got_q[0] !== 16'h16E5) begin n_errors++; $display("FAIL capt_only: got %0d moves, required just 16e5", got_q.size()); end
`else
        if (got_q.size() != 8 || got_q[1] !== 16'h16E5) begin n_errors++; $display("FAIL capt_flag: got %0d moves, required 8 with 16e5 second", got_q.size()); end
`endif
    endtask

    task automatic test_saturation();
        bit to;
        int exp_cnt;
        clear_board();
        for (int sq = 0; sq < 64; sq++)
            if (((sq / 8) + (sq % 8)) % 2 == 0) place(T_KNIGHT, sq / 8, sq % 8, WHITE);
        model_scan(WHITE);
        exp_cnt = (exp_q.size() > MAX_CNT) ? MAX_CNT : exp_q.size();
        move_ready = 1'b1;
        start_scan(WHITE);
        wait_done(to);
        n_checks++;
        if (to) begin n_errors++; $display("FAIL sat_timeout: no done within budget"); end
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL sat_nmoves: got %0d required %0d", got_q.size(), exp_q.size()); end
        n_checks++;
        if (move_count !== COUNT_W'(exp_cnt)) begin n_errors++; $display("FAIL sat_count: got %0d required %0d", move_count, exp_cnt); end
    endtask

    task automatic test_random();
        bit to;
        logic s;
        int exp_cnt;
        for (int it = 0; it < 6; it++) begin
            clear_board();
            for (int sq = 0; sq < 64; sq++) begin
                int r = $urandom_range(0, 9);
                if (r >= 6) begin
                    logic [2:0] t = (r < 8) ? T_KNIGHT : 3'($urandom_range(1, 6));
                    place(t, sq / 8, sq % 8, 1'($urandom_range(0, 1)));
                end
            end
            s = 1'($urandom_range(0, 1));
            model_scan(s);
            exp_cnt = (exp_q.size() > MAX_CNT) ? MAX_CNT : exp_q.size();
            rand_ready = 1'b1;
            start_scan(s);
            wait_done(to);
            rand_ready = 1'b0;
            n_checks++;
            if (to) begin n_errors++; $display("FAIL rand%0d_timeout: no done within budget", it); end
            n_checks++;
            if (got_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rand%0d_nmoves: got %0d required %0d", it, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rand%0d_move%0d: got %h required %h", it, i, got_q[i], exp_q[i]); end
            end
            n_checks++;
            if (move_count !== COUNT_W'(exp_cnt) || done_cnt != 1) begin
                n_errors++; $display("FAIL rand%0d_count: got cnt=%0d done=%0d required %0d and 1", it, move_count, done_cnt, exp_cnt);
            end
        end
    endtask

    initial begin
        clear_board();
        test_reset();
        test_lone_center();
        test_corner();
        test_wrong_side();
        test_stall();
        test_abort();
        test_reset_mid_emit();
        test_captures_only();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
